// File: rtl/sram_port_arbiter_if.sv
// Handshake bundle between the IF/MEM requesters, the arbiter and the SRAM.
// master: requesters plus SRAM read data; slave: the arbiter.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;
    logic                  sram_en;
    logic [DATA_W/8-1:0]   sram_wen;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_wdata;
    logic [DATA_W-1:0]     sram_rdata;

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output sram_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  sram_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: data requester wins, fetch forced after
// STARVE_MAX data grants. Ports: clk, reset, bus (slave modport).
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    sram_port_arbiter_if.slave  bus
);
    localparam int          SW   = DATA_W / 8;
    localparam logic [3:0]  SMAX = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt;
    logic              resp_v;
    logic              resp_owner;
    logic              force_inst;
    logic              gnt_i;
    logic              gnt_d;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic [SW-1:0]     wen_mux;

    // Grants are suppressed during reset so nothing reaches the SRAM.
    always_comb begin
        force_inst = bus.inst_req & (starve_cnt == SMAX);
        gnt_d      = ~reset & bus.data_req & ~force_inst;
        gnt_i      = ~reset & bus.inst_req & (~bus.data_req | force_inst);
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        wen_mux   = '0;
        if (gnt_d) begin
            addr_mux  = bus.data_addr;
            wdata_mux = bus.data_wdata;
            wen_mux   = bus.data_wr ? bus.data_wstrb : '0;
        end else if (gnt_i) begin
            addr_mux  = bus.inst_addr;
        end
    end

    assign bus.inst_addr_ok = gnt_i;
    assign bus.data_addr_ok = gnt_d;
    assign bus.sram_en      = gnt_i | gnt_d;
    assign bus.sram_wen     = wen_mux;
    assign bus.sram_addr    = addr_mux;
    assign bus.sram_wdata   = wdata_mux;

    // A response registered just before reset rose is dropped here.
    assign bus.inst_data_ok = ~reset & resp_v & ~resp_owner;
    assign bus.data_data_ok = ~reset & resp_v & resp_owner;
    assign bus.inst_rdata   = reset ? '0 : bus.sram_rdata;
    assign bus.data_rdata   = reset ? '0 : bus.sram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_v     <= 1'b0;
            resp_owner <= 1'b0;
            starve_cnt <= '0;
        end else begin
            resp_v     <= gnt_i | gnt_d;
            resp_owner <= gnt_d;
            if (gnt_i | ~bus.inst_req) begin
                starve_cnt <= '0;
            end else if (gnt_d && starve_cnt != SMAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised scoreboard bench for sram_port_arbiter with an SRAM model.
// Ports: none (top-level bench).
module tb_sram_port_arbiter;
    localparam int STARVE_MAX = 4;

    typedef struct {
        int          due;
        bit          is_data;
        bit          is_wr;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        reset;
    int          cyc;
    int          n_checks;
    int          n_err;
    int          ref_starve;
    logic [31:0] ref_mem  [64];
    logic [31:0] sram_mem [64];
    exp_t        q [$];
    string       last_g;
    string       pat;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: reloaded from the reference image while in reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= ref_mem[i];
            bus.sram_rdata <= '0;
        end else if (bus.sram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_wen[b])
                    sram_mem[bus.sram_addr[7:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            bus.sram_rdata <= sram_mem[bus.sram_addr[7:2]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the response due this cycle and compares it.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("rst_inst_data_ok", 64'(bus.inst_data_ok), 0);
            chk("rst_data_data_ok", 64'(bus.data_data_ok), 0);
            chk("rst_inst_rdata", 64'(bus.inst_rdata), 0);
            chk("rst_data_rdata", 64'(bus.data_rdata), 0);
            while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        end else if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("resp_inst_data_ok", 64'(bus.inst_data_ok), 64'(!e.is_data));
            chk("resp_data_data_ok", 64'(bus.data_data_ok), 64'(e.is_data));
            if (!e.is_wr) begin
                if (e.is_data) chk("data_rdata", 64'(bus.data_rdata), 64'(e.rdata));
                else           chk("inst_rdata", 64'(bus.inst_rdata), 64'(e.rdata));
            end
        end else begin
            chk("idle_inst_data_ok", 64'(bus.inst_data_ok), 0);
            chk("idle_data_data_ok", 64'(bus.data_data_ok), 0);
        end
    end

    // Drive one cycle, predict the grant from the arbitration rules,
    // check the request-side outputs and queue the expected response.
    task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw, input logic [3:0] ds,
                        input logic [31:0] da, input logic [31:0] dd);
        bit   gi, gd, frc;
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        bus.inst_req   = ir;
        bus.inst_addr  = ia;
        bus.data_req   = dr;
        bus.data_wr    = dw;
        bus.data_wstrb = ds;
        bus.data_addr  = da;
        bus.data_wdata = dd;
        @(negedge clk);
        frc = ir && (ref_starve >= STARVE_MAX);
        gd  = !rst && dr && !frc;
        gi  = !rst && ir && !gd;
        chk("inst_addr_ok", 64'(bus.inst_addr_ok), 64'(gi));
        chk("data_addr_ok", 64'(bus.data_addr_ok), 64'(gd));
        chk("sram_en", 64'(bus.sram_en), 64'(gi || gd));
        chk("sram_wen", 64'(bus.sram_wen), 64'((gd && dw) ? ds : 4'd0));
        chk("sram_addr", 64'(bus.sram_addr), 64'(gd ? da : (gi ? ia : 32'd0)));
        chk("sram_wdata", 64'(bus.sram_wdata), 64'(gd ? dd : 32'd0));
        if (gi) begin
            e = '{due: cyc + 1, is_data: 1'b0, is_wr: 1'b0, rdata: ref_mem[ia[7:2]]};
            q.push_back(e);
        end
        if (gd) begin
            e = '{due: cyc + 1, is_data: 1'b1, is_wr: dw, rdata: ref_mem[da[7:2]]};
            q.push_back(e);
            if (dw)
                for (int b = 0; b < 4; b++)
                    if (ds[b]) ref_mem[da[7:2]][8*b +: 8] = dd[8*b +: 8];
        end
        if (rst || gi || !ir) ref_starve = 0;
        else if (gd && ref_starve < STARVE_MAX) ref_starve++;
        last_g = gd ? "D" : (gi ? "I" : "-");
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_pat(input string name, input string exp);
        n_checks++;
        if (pat != exp) begin
            n_err++;
            $display("FAIL %s: got %s expected %s", name, pat, exp);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_err      = 0;
        ref_starve = 0;
        reset      = 1'b1;
        bus.inst_req = 0; bus.inst_addr = 0; bus.data_req = 0;
        bus.data_wr = 0; bus.data_wstrb = 0; bus.data_addr = 0;
        bus.data_wdata = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'h02c00000;

        for (int i = 0; i < 3; i++)
            step(1, 1, 32'h1c000000, 1, 0, 0, 32'h40, 0);
        step(0, 1, 32'h1c000000, 1, 0, 0, 32'h40, 0);
        pat = last_g;
        chk_pat("first_grant", "D");
        idle();

        step(0, 1, 32'h1c000000, 0, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, 1, 1, 4'b0011, 32'h80, 32'hdeadbeef);
        step(0, 0, 0, 1, 0, 4'b0000, 32'h80, 0);
        idle();

        pat = "";
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 32'h100 + 32'(4 * i), 1, 0, 0, 32'h200 + 32'(4 * i), 0);
            pat = {pat, last_g};
        end
        chk_pat("starve_pattern", "DDDDIDDDDIDD");
        idle();

        step(0, 0, 0, 1, 0, 0, 32'h84, 0);
        step(0, 1, 32'h88, 0, 0, 0, 0, 0);
        idle();

        step(0, 1, 32'h10, 1, 0, 0, 32'h14, 0);
        step(0, 1, 32'h10, 1, 0, 0, 32'h18, 0);
        step(1, 1, 32'h10, 1, 0, 0, 32'h18, 0);
        pat = "";
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h20, 1, 1, 4'hf, 32'h24, 32'(i));
            pat = {pat, last_g};
        end
        chk_pat("starve_after_reset", "DDDDI");
        idle();

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom), $urandom,
                 1'($urandom), 1'($urandom), 4'($urandom),
                 $urandom, $urandom);
        end
        idle();
        idle();
        idle();
        chk("queue_drained", 64'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
